// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared sizing, types and constants for the 16-entry register file and its
// write-enable decoder.
//   NREGS        : number of architectural registers
//   ADDR_W       : register index width
//   reg_addr_t   : register index type
//   reg_data_t   : register data type (64 bits)
//   ZERO_REG_IDX : index of the hardwired zero register
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [63:0]       reg_data_t;

  localparam reg_addr_t ZERO_REG_IDX = 4'd15;

endpackage : regfile_pkg

// File: rtl/decoder_4to16.sv
// -----------------------------------------------------------------------------
// decoder_4to16
// Gated 4-to-16 one-hot decoder producing per-register write strobes.
// At most one output bit is set; none when en is low.
// Ports:
//   en     : input  decode enable (write enable)
//   addr   : input  [ADDR_W-1:0] register index
//   onehot : output [NREGS-1:0]  one-hot write strobes
// -----------------------------------------------------------------------------
module decoder_4to16
  import regfile_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREGS-1:0]  onehot
);

  // One-hot decode of the index, forced to all-zero when disabled.
  always_comb begin
    onehot = {NREGS{1'b0}};
    if (en) begin
      onehot = {{(NREGS-1){1'b0}}, 1'b1} << addr;
    end else begin
      onehot = {NREGS{1'b0}};
    end
  end

endmodule : decoder_4to16

// File: rtl/regfile_16x64.sv
// -----------------------------------------------------------------------------
// regfile_16x64
// 16-entry register file, two combinational read ports, one synchronous write
// port. Entry ZERO_REG has no storage: it always reads zero and drops writes.
// Reset is synchronous and active-low; it clears every entry and wins over a
// write in the same cycle.
//
// Optional build macro: REGFILE_BYPASS_EN
//   When defined, a read whose index matches an active write (reset_n high,
//   index not ZERO_REG) returns wr_data in the same cycle (write-first).
//   When undefined, such a read returns the stored (old) value until the edge.
//
// Ports:
//   clk        : input  system clock, state updates on posedge
//   reset_n    : input  synchronous active-low reset
//   wr_en      : input  write enable
//   wr_addr    : input  [3:0]       write index
//   wr_data    : input  [WIDTH-1:0] write data
//   rd_addr_a  : input  [3:0]       read port A index
//   rd_addr_b  : input  [3:0]       read port B index
//   rd_data_a  : output [WIDTH-1:0] read port A data (combinational)
//   rd_data_b  : output [WIDTH-1:0] read port B data (combinational)
// -----------------------------------------------------------------------------
module regfile_16x64
  import regfile_pkg::*;
#(
  parameter int WIDTH    = $bits(reg_data_t),
  parameter int ZERO_REG = int'(ZERO_REG_IDX)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b
);

  logic [NREGS-1:0] wr_sel;
  logic [WIDTH-1:0] reg_val [NREGS];
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;

  decoder_4to16 u_wr_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (wr_sel)
  );

  // Per-register storage; the zero register is a constant, not a flop.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      // The decoder still raises a strobe for this index; it is deliberately dropped.
      logic unused_zero_sel;
      assign unused_zero_sel = wr_sel[g];
      assign reg_val[g]      = {WIDTH{1'b0}};
    end else begin : g_flop
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;

      // Next value: load on this register's strobe, otherwise hold.
      always_comb begin
        data_d = data_q;
        if (wr_sel[g]) begin
          data_d = wr_data;
        end else begin
          data_d = data_q;
        end
      end

      // Storage flop; reset is sampled on the edge and overrides any write.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          data_q <= {WIDTH{1'b0}};
        end else begin
          data_q <= data_d;
        end
      end

      assign reg_val[g] = data_q;
    end
  end

  // Bit-sliced read muxes: each data bit gathers its 16-bit slice across the
  // registers and selects one bit per port.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NREGS-1:0] slice;
    for (genvar r = 0; r < NREGS; r++) begin : g_slice
      assign slice[r] = reg_val[r][b];
    end
    assign mux_a[b] = slice[rd_addr_a];
    assign mux_b[b] = slice[rd_addr_b];
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic fwd_a;
  logic fwd_b;

  // Forwarding qualifies: live write, not in reset, index match, not the zero register.
  always_comb begin
    fwd_a = reset_n & wr_en & (wr_addr == rd_addr_a) & (wr_addr != ZERO_ADDR);
    fwd_b = reset_n & wr_en & (wr_addr == rd_addr_b) & (wr_addr != ZERO_ADDR);
  end

  // Output select: forwarded write data or the stored value, per port.
  always_comb begin
    rd_data_a = mux_a;
    rd_data_b = mux_b;
    if (fwd_a) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = mux_a;
    end
    if (fwd_b) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = mux_b;
    end
  end
`else
  assign rd_data_a = mux_a;
  assign rd_data_b = mux_b;
`endif

endmodule : regfile_16x64

// File: tb/tb_regfile_16x64.sv
// -----------------------------------------------------------------------------
// tb_regfile_16x64
// Self-checking bench for regfile_16x64. A plain array holds the expected
// register contents; reads are predicted from it (plus same-cycle forwarding
// when REGFILE_BYPASS_EN is defined). Inputs change on the falling edge,
// reads are checked just before and just after each rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_16x64;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [16];

  regfile_16x64 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected read value for an index given the inputs currently applied.
  function automatic logic [63:0] expect_rd(input logic [3:0] addr);
    logic [63:0] v;
    if (addr == 4'd15) v = 64'h0;
    else               v = model[addr];
`ifdef REGFILE_BYPASS_EN
    if (reset_n && wr_en && (wr_addr == addr) && (addr != 4'd15)) v = wr_data;
`endif
    return v;
  endfunction

  // Apply inputs on the falling edge and check the reads before the rising edge.
  task automatic drive(input logic rn, input logic we, input logic [3:0] wa,
                       input logic [63:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    @(negedge clk);
    reset_n   = rn;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    #1;
    check("pre_edge_a", rd_data_a, expect_rd(ra));
    check("pre_edge_b", rd_data_b, expect_rd(rb));
  endtask

  // Take the rising edge, update the model, check the reads just after it.
  task automatic edge_post();
    @(posedge clk);
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) model[i] = 64'h0;
    end else if (wr_en && wr_addr != 4'd15) begin
      model[wr_addr] = wr_data;
    end
    #1;
    check("post_edge_a", rd_data_a, expect_rd(rd_addr_a));
    check("post_edge_b", rd_data_b, expect_rd(rd_addr_b));
  endtask

  task automatic cycle(input logic rn, input logic we, input logic [3:0] wa,
                       input logic [63:0] wd, input logic [3:0] ra, input logic [3:0] rb);
    drive(rn, we, wa, wd, ra, rb);
    edge_post();
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 4'd0;
    wr_data   = 64'h0;
    rd_addr_a = 4'd0;
    rd_addr_b = 4'd0;
    for (int i = 0; i < 16; i++) model[i] = 64'h0;

    // Initial reset edge: storage is undefined beforehand, so no pre-edge check.
    @(posedge clk);
    #1;
    check("reset_a0", rd_data_a, 64'h0);

    // All addresses read zero after reset on both ports.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 4'd0, 64'h0, 4'(i), 4'(15 - i));
      check("reset_all_a", rd_data_a, 64'h0);
      check("reset_all_b", rd_data_b, 64'h0);
    end

    // Write reg3, read it back on A; B on reg4 stays zero.
    cycle(1'b1, 1'b1, 4'd3, 64'hDEADBEEF_CAFEF00D, 4'd3, 4'd4);
    check("reg3_a", rd_data_a, 64'hDEADBEEF_CAFEF00D);
    check("reg4_b", rd_data_b, 64'h0);

    // Writes to the zero register are discarded, including in the write cycle.
    drive(1'b1, 1'b1, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 4'd3);
    check("zero_same_cycle", rd_data_a, 64'h0);
    edge_post();
    check("zero_after", rd_data_a, 64'h0);

    // Read-during-write on reg7.
    cycle(1'b1, 1'b1, 4'd7, 64'h1111, 4'd7, 4'd7);
    drive(1'b1, 1'b1, 4'd7, 64'h2222, 4'd7, 4'd3);
`ifdef REGFILE_BYPASS_EN
    check("rdw_same_cycle", rd_data_a, 64'h2222);
`else
    check("rdw_same_cycle", rd_data_a, 64'h1111);
`endif
    edge_post();
    check("rdw_next_cycle", rd_data_a, 64'h2222);

    // wr_en low leaves reg5 untouched.
    cycle(1'b1, 1'b0, 4'd5, 64'hABCD, 4'd5, 4'd5);
    check("no_write_reg5", rd_data_a, 64'h0);

    // Reset wins over a simultaneous write; writes resume after reset.
    cycle(1'b0, 1'b1, 4'd9, 64'h55, 4'd9, 4'd3);
    check("reset_drop_reg9", rd_data_a, 64'h0);
    check("reset_clears_reg3", rd_data_b, 64'h0);
    cycle(1'b1, 1'b1, 4'd9, 64'h77, 4'd9, 4'd9);
    check("reg9_a", rd_data_a, 64'h77);
    check("reg9_b", rd_data_b, 64'h77);

    // Randomized traffic with frequent address collisions and rare resets.
    for (int n = 0; n < 400; n++) begin
      logic        rn;
      logic        we;
      logic [3:0]  wa;
      logic [63:0] wd;
      logic [3:0]  ra;
      logic [3:0]  rb;
      rn = ($urandom_range(0, 24) != 0);
      we = ($urandom_range(0, 3) != 0);
      wa = 4'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      cycle(rn, we, wa, wd, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_16x64
